mult_bus_host: RTL and testbench

//  Bus initiator for the shared multiplier data port: takes operands a/b plus a
//  one-cycle req, writes M then Q over the tristate bus, presses the active-low

---
 rtl/mult_bus_host_if.sv | 30 +++
 rtl/mult_bus_host.sv | 203 ++++++++++++++++++++
 tb/tb_mult_bus_host.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_bus_host_if.sv
// Controller-side handshake and multiplier control pins for mult_bus_host.
// The shared data bus stays a plain inout on the host so the tristate net
// is resolved at the level where both drivers meet.
interface mult_bus_host_if #(
    parameter int n = 8
);
    logic             req;
    logic [n-1:0]     a;
    logic [n-1:0]     b;
    logic             busy;
    logic             done;
    logic             err;
    logic [2*n-1:0]   product;
    logic [1:0]       func;
    logic             oe;
    logic             startPB;
    logic             ready;

    // Host side: accepts requests, commands the responder.
    modport master (
        input  req, a, b, ready,
        output busy, done, err, product, func, oe, startPB
    );

    // Requester / responder side.
    modport slave (
        output req, a, b, ready,
        input  busy, done, err, product, func, oe, startPB
    );
endinterface

// File: rtl/mult_bus_host.sv
// Bus initiator for the shared multiplier data port. Loads M and Q, presses
// the debounced start line, waits for the responder to go busy and idle
// again, then reads the product low half followed by the high half.
// All pin outputs are registered and decoded from the next state so they
// line up with the state they belong to.
module mult_bus_host #(
    parameter int n       = 8,
    parameter int PRESS   = 3330,
    parameter int RELEASE = 3330,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              nReset,
    mult_bus_host_if.master   bus,
    inout  wire  [n-1:0]      data
);

    localparam int PR_MAX  = (PRESS > RELEASE) ? PRESS : RELEASE;
    localparam int CNT_MAX = (PR_MAX > TIMEOUT) ? PR_MAX : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE - 1);
    localparam logic [CW-1:0] TIMEOUT_LIM  = CW'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_M, S_LOAD_Q, S_PRESS, S_REL, S_WAIT_LO, S_WAIT_HI,
        S_RD_LO0, S_RD_LO1, S_RD_HI0, S_RD_HI1, S_DONE, S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [n-1:0]    a_q, a_d, b_q, b_d, lo_q, lo_d;
    logic [2*n-1:0]  product_q, product_d;
    logic [1:0]      func_q, func_d;
    logic            oe_q, oe_d;
    logic            start_pb_q, start_pb_d;
    logic            drive_q, drive_d;
    logic [n-1:0]    dout_q, dout_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;

    // Counter never exceeds CNT_MAX, so the increment cannot wrap.
    assign cnt_inc = cnt_q + CW'(1);

    // Next-state, counter and data-capture logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        lo_d      = lo_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = S_LOAD_M;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_M: state_d = S_LOAD_Q;
            S_LOAD_Q: begin
                cnt_d   = {CW{1'b0}};
                state_d = S_PRESS;
            end
            S_PRESS: begin
                if (cnt_q >= PRESS_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_REL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_REL: begin
                if (cnt_q >= RELEASE_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_WAIT_LO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_LO: begin
                // cnt_inc counts cycles spent here including the current one.
                if (!bus.ready) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_WAIT_HI;
                end else if (cnt_inc >= TIMEOUT_LIM) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_HI: begin
                if (bus.ready) begin
                    state_d = S_RD_LO0;
                end else if (cnt_inc >= TIMEOUT_LIM) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RD_LO0: state_d = S_RD_LO1;
            S_RD_LO1: begin
                lo_d    = data;
                state_d = S_RD_HI0;
            end
            S_RD_HI0: state_d = S_RD_HI1;
            S_RD_HI1: begin
                // High half joins the held low half so product is valid in DONE.
                product_d = {data, lo_q};
                state_d   = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Pin and status decode for the state being entered; park is func=10/oe=0.
    always_comb begin
        func_d     = 2'b10;
        oe_d       = 1'b0;
        start_pb_d = 1'b1;
        drive_d    = 1'b0;
        dout_d     = {n{1'b0}};
        case (state_d)
            S_LOAD_M: begin
                func_d  = 2'b00;
                drive_d = 1'b1;
                dout_d  = a_d;
            end
            S_LOAD_Q: begin
                func_d  = 2'b01;
                drive_d = 1'b1;
                dout_d  = b_d;
            end
            S_PRESS:  start_pb_d = 1'b0;
            S_RD_LO0, S_RD_LO1: begin
                func_d = 2'b10;
                oe_d   = 1'b1;
            end
            S_RD_HI0, S_RD_HI1: begin
                func_d = 2'b11;
                oe_d   = 1'b1;
            end
            default: begin
                func_d = 2'b10;
                oe_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_FAIL);
    end

    // State, datapath and output registers; reset releases the bus at once.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CW{1'b0}};
            a_q        <= {n{1'b0}};
            b_q        <= {n{1'b0}};
            lo_q       <= {n{1'b0}};
            product_q  <= {(2*n){1'b0}};
            func_q     <= 2'b10;
            oe_q       <= 1'b0;
            start_pb_q <= 1'b1;
            drive_q    <= 1'b0;
            dout_q     <= {n{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            lo_q       <= lo_d;
            product_q  <= product_d;
            func_q     <= func_d;
            oe_q       <= oe_d;
            start_pb_q <= start_pb_d;
            drive_q    <= drive_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Host drives only during loads, which never coincide with oe=1.
    assign data        = drive_q ? dout_q : {n{1'bz}};
    assign bus.func    = func_q;
    assign bus.oe      = oe_q;
    assign bus.startPB = start_pb_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_mult_bus_host.sv
// Bench for mult_bus_host: a behavioural multiplier responder on the bus,
// a table of directed operations, hand sequences for the multi-cycle corner
// cases and randomized operations checked against an arithmetic model.
module tb_mult_bus_host;
    localparam int N = 8;
    localparam int P = 4;
    localparam int R = 4;
    localparam int T = 16;

    logic clk;
    logic nReset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mult_bus_host_if #(.n(N)) bus_if();
    // Released bus reads as all ones.
    tri1 [N-1:0] data;

    mult_bus_host #(.n(N), .PRESS(P), .RELEASE(R), .TIMEOUT(T)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus_if),
        .data   (data)
    );

    int checks   = 0;
    int failures = 0;
    int mon_err  = 0;

    // ---------------- responder model ----------------
    logic [N-1:0]   m_r = 8'h00;
    logic [N-1:0]   q_r = 8'h00;
    logic [2*N-1:0] prod_r = 16'h0000;
    logic           ready_r = 1'b1;
    int             low_run = 0;
    int             press_len = 0;
    int             rel_wait = 0;
    int             resp_extra = 0;
    bit             resp_stuck = 1'b0;
    logic [1:0]     wr_func[$];
    logic [N-1:0]   wr_data[$];
    logic [1:0]     rd_seq[$];
    logic           resp_en;
    logic [N-1:0]   resp_val;

    assign bus_if.ready = ready_r;

    always_comb begin
        resp_en  = bus_if.oe && bus_if.func[1];
        resp_val = bus_if.func[0] ? prod_r[15:8] : prod_r[7:0];
    end
    assign data = resp_en ? resp_val : 8'hzz;

    // Responder: latches loads, debounces the press, goes busy after release.
    always @(posedge clk) begin
        if (!bus_if.oe && !bus_if.func[1]) begin
            wr_func.push_back(bus_if.func);
            wr_data.push_back(data);
            if (bus_if.func[0]) q_r <= data;
            else                m_r <= data;
        end
        if (bus_if.oe) rd_seq.push_back(bus_if.func);
        if (rel_wait > 0) begin
            if (rel_wait == 1) ready_r <= 1'b1;
            rel_wait <= rel_wait - 1;
        end
        if (!bus_if.startPB) begin
            low_run <= low_run + 1;
        end else begin
            if (low_run > 0) begin
                press_len <= low_run;
                if (low_run >= 2 && !resp_stuck) begin
                    prod_r   <= 16'(m_r) * 16'(q_r);
                    ready_r  <= 1'b0;
                    rel_wait <= R + resp_extra;
                end
            end
            low_run <= 0;
        end
    end

    // Bus monitor: no drive by the host outside loads, no oe during loads.
    always @(negedge clk) begin
        if (nReset) begin
            if (bus_if.oe && !bus_if.func[1]) begin
                mon_err <= mon_err + 1;
                if (mon_err < 5) $display("FAIL bus_oe_in_load func=%b oe=%b", bus_if.func, bus_if.oe);
            end else if (bus_if.oe && data !== resp_val) begin
                mon_err <= mon_err + 1;
                if (mon_err < 5) $display("FAIL bus_contention got=0x%0h exp=0x%0h", data, resp_val);
            end else if (!bus_if.oe && bus_if.func[1] && data !== 8'hFF) begin
                mon_err <= mon_err + 1;
                if (mon_err < 5) $display("FAIL bus_not_released got=0x%0h exp=0xff", data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // One operation started at a negedge with the host idle.
    // Success latency: req cycle + 2 loads + P + R + one WAIT_LO cycle +
    // (1 + extra) WAIT_HI cycles + 4 reads -> DONE at 9 + P + R + extra.
    // Timeout: WAIT_LO entered at cycle 3 + P + R, err T cycles later.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tv, input int extra,
                          input bit stuck, input bit spam, input logic [15:0] exp_prod);
        int   lat;
        int   busy_drop;
        bit   seen;
        logic [31:0] rs;
        resp_extra = extra;
        resp_stuck = stuck;
        wr_func.delete();
        wr_data.delete();
        rd_seq.delete();
        bus_if.a   = ta;
        bus_if.b   = tv;
        bus_if.req = 1'b1;
        lat = 0;
        busy_drop = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (!bus_if.busy) busy_drop++;
            if (bus_if.done || bus_if.err) begin
                seen = 1'b1;
            end else begin
                bus_if.req = spam;
                if (spam) begin
                    bus_if.a = 8'($urandom_range(0, 255));
                    bus_if.b = 8'($urandom_range(0, 255));
                end
            end
        end
        if (!spam) bus_if.req = 1'b0;
        chk("op_finished", 32'(seen), 32'd1);
        chk("busy_held", 32'(busy_drop), 32'd0);
        chk("latency", 32'(lat), stuck ? 32'(3 + P + R + T) : 32'(9 + P + R + extra));
        chk("done_flag", 32'(bus_if.done), stuck ? 32'd0 : 32'd1);
        chk("err_flag", 32'(bus_if.err), stuck ? 32'd1 : 32'd0);
        chk("product", 32'(bus_if.product), 32'(exp_prod));
        chk("write_count", 32'(wr_func.size()), 32'd2);
        chk("write_seq", 32'({wr_func[0], wr_data[0], wr_func[1], wr_data[1]}),
            32'({2'b00, ta, 2'b01, tv}));
        chk("press_len", 32'(press_len), 32'(P));
        rs = 32'd0;
        foreach (rd_seq[i]) rs = {rs[29:0], rd_seq[i]};
        chk("read_order", {8'(rd_seq.size()), rs[23:0]},
            stuck ? 32'd0 : {8'd4, 24'h0000AF});
        @(negedge clk);
        bus_if.req = 1'b0;
        chk("post_busy", {29'd0, bus_if.busy, bus_if.done, bus_if.err}, 32'd0);
        if (spam) begin
            busy_drop = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus_if.busy || bus_if.done) busy_drop++;
            end
            chk("no_second_op", 32'(busy_drop), 32'd0);
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          extra;
        bit          stuck;
        logic [15:0] exp_prod;
    } vec_t;

    vec_t        vecs[6];
    logic [15:0] last_prod;
    logic [7:0]  ra, rb;
    bit          rstuck;
    logic [15:0] rexp;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'd3,   8'd5,   0, 1'b0, 16'h000F};
        vecs[1] = '{8'd255, 8'd255, 2, 1'b0, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 1, 1'b0, 16'h0000};
        vecs[3] = '{8'd1,   8'd1,   0, 1'b0, 16'h0001};
        vecs[4] = '{8'd7,   8'd9,   0, 1'b1, 16'h0001};
        vecs[5] = '{8'd12,  8'd34,  3, 1'b0, 16'h0198};

        nReset     = 1'b0;
        bus_if.req = 1'b0;
        bus_if.a   = 8'h00;
        bus_if.b   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy",    32'(bus_if.busy), 32'd0);
        chk("rst_done",    32'(bus_if.done), 32'd0);
        chk("rst_err",     32'(bus_if.err), 32'd0);
        chk("rst_product", 32'(bus_if.product), 32'd0);
        chk("rst_func",    32'(bus_if.func), 32'd2);
        chk("rst_oe",      32'(bus_if.oe), 32'd0);
        chk("rst_startPB", 32'(bus_if.startPB), 32'd1);
        chk("rst_data_z",  32'(data), 32'hFF);
        nReset = 1'b1;
        @(negedge clk);

        // Directed table, run back to back (one idle cycle between ops).
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].extra, vecs[i].stuck, 1'b0, vecs[i].exp_prod);
        end
        last_prod = 16'h0198;

        // req hammered while busy and on the DONE cycle: one operation only.
        run_op(8'h11, 8'h0D, 1, 1'b0, 1'b1, 16'h00DD);
        last_prod = 16'h00DD;

        // Reset asserted while waiting for ready to return.
        resp_extra = 5;
        resp_stuck = 1'b0;
        bus_if.a   = 8'h5A;
        bus_if.b   = 8'h33;
        bus_if.req = 1'b1;
        @(negedge clk);
        bus_if.req = 1'b0;
        repeat (12) @(negedge clk);
        chk("whi_oe_before", 32'(bus_if.oe), 32'd0);
        chk("whi_busy_before", 32'(bus_if.busy), 32'd1);
        nReset = 1'b0;
        #1;
        chk("arst_data_z",  32'(data), 32'hFF);
        chk("arst_oe",      32'(bus_if.oe), 32'd0);
        chk("arst_startPB", 32'(bus_if.startPB), 32'd1);
        chk("arst_busy",    32'(bus_if.busy), 32'd0);
        chk("arst_func",    32'(bus_if.func), 32'd2);
        chk("arst_product", 32'(bus_if.product), 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        repeat (12) @(negedge clk);
        last_prod = 16'h0000;
        run_op(8'd9, 8'd7, 0, 1'b0, 1'b0, 16'd63);
        last_prod = 16'd63;

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 10; i++) begin
            ra     = 8'($urandom_range(0, 255));
            rb     = 8'($urandom_range(0, 255));
            rstuck = ($urandom_range(0, 5) == 0);
            rexp   = rstuck ? last_prod : 16'(ra) * 16'(rb);
            run_op(ra, rb, $urandom_range(0, 5), rstuck, 1'b0, rexp);
            last_prod = rexp;
        end

        chk("bus_monitor", 32'(mon_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
